// File: rtl/koto_trig_pkg.sv
// Shared types and default widths for the trigger pulse shaper.
package koto_trig_pkg;

  localparam int PW_BITS_DEF  = 8;
  localparam int DT_BITS_DEF  = 16;
  localparam int CNT_BITS_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_DEAD  = 2'd2
  } trig_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency 1 cycle from i_inc/i_clr to o_cnt; no backpressure.
module sat_counter
  import koto_trig_pkg::*;
#(
  parameter int W = CNT_BITS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/trig_pulse_shaper.sv
// Edge-to-pulse shaper: IDLE->PULSE(W)->DEAD(D), outputs registered (1 cycle after accept), no backpressure.
// Veto input is honoured only when TRIG_SHAPER_VETO_EN is defined.
module trig_pulse_shaper
  import koto_trig_pkg::*;
#(
  parameter int PW_BITS  = PW_BITS_DEF,
  parameter int DT_BITS  = DT_BITS_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                edge_in,
  input  logic                enable,
  input  logic                veto,
  input  logic [PW_BITS-1:0]  pulse_width,
  input  logic [DT_BITS-1:0]  dead_time,
  input  logic                cnt_clear,
  output logic                trig_out,
  output logic                busy,
  output logic                accept_strobe,
  output logic [CNT_BITS-1:0] accept_cnt,
  output logic [CNT_BITS-1:0] reject_cnt
);

  localparam int TW = max_int(PW_BITS, DT_BITS);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  trig_state_e         r_state;
  logic [TW-1:0]       r_tmr;
  logic [DT_BITS-1:0]  r_dt;
  logic                r_trig;
  logic                r_busy;
  logic                r_strobe;

  logic                w_veto;
  logic                w_accept;
  logic                w_reject;
  logic [TW-1:0]       w_pw_eff;

`ifdef TRIG_SHAPER_VETO_EN
  assign w_veto = veto;
`else
  logic w_veto_unused;
  assign w_veto_unused = veto;
  assign w_veto        = 1'b0;
`endif

  assign w_accept = (r_state == ST_IDLE) && edge_in && enable && !w_veto;
  assign w_reject = edge_in && enable && !w_accept;
  // A zero width still produces a single-cycle pulse.
  assign w_pw_eff = (pulse_width == '0) ? T_ONE : TW'(pulse_width);

  // r_tmr holds the cycles left in the current state, including the present one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_tmr    <= '0;
      r_dt     <= '0;
      r_trig   <= 1'b0;
      r_busy   <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_accept;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_PULSE;
            r_tmr   <= w_pw_eff;
            r_dt    <= dead_time;
            r_trig  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (r_tmr == T_ONE) begin
            r_trig <= 1'b0;
            if (r_dt == '0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DEAD;
              r_tmr   <= TW'(r_dt);
            end
          end else begin
            r_tmr <= r_tmr - T_ONE;
          end
        end
        ST_DEAD: begin
          if (r_tmr == T_ONE) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmr <= r_tmr - T_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_trig  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_BITS)) u_accept_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_accept),
    .i_clr (cnt_clear),
    .o_cnt (accept_cnt)
  );

  sat_counter #(.W(CNT_BITS)) u_reject_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_reject),
    .i_clr (cnt_clear),
    .o_cnt (reject_cnt)
  );

  assign trig_out      = r_trig;
  assign busy          = r_busy;
  assign accept_strobe = r_strobe;

endmodule
